// File: rtl/bits_buffered_if.sv
// Handshake bundle for the buffered bit/slice dumper: word input side and
// serialised readback side, seen from the dumper as the slave.
interface bits_buffered_if #(
    parameter int WIDTH     = 32,
    parameter int LOG_DEPTH = 2
);
    logic [WIDTH-1:0]   in_data_i;
    logic               in_nd_i;
    logic               mode_i;
    logic [WIDTH-1:0]   out_data_o;
    logic               out_nd_o;
    logic               error_o;
    logic [LOG_DEPTH:0] fifo_count_o;

    modport master (
        output in_data_i, in_nd_i, mode_i,
        input  out_data_o, out_nd_o, error_o, fifo_count_o
    );

    modport slave (
        input  in_data_i, in_nd_i, mode_i,
        output out_data_o, out_nd_o, error_o, fifo_count_o
    );
endinterface

// File: rtl/bits_buffered.sv
// Buffers words in a small FIFO and serialises each one as CHUNK-bit slices,
// MSB slice first, as (index, value) pairs or values only; overflow is sticky.
module bits_buffered #(
    parameter int               WIDTH      = 32,
    parameter int               CHUNK      = 1,
    parameter int               LOG_NCHUNK = 5,
    parameter int               DEPTH      = 4,
    parameter int               LOG_DEPTH  = 2,
    parameter logic [WIDTH-1:0] ERRORCODE  = {WIDTH{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    bits_buffered_if.slave    bus
);
    localparam int                   NCHUNK     = WIDTH / CHUNK;
    localparam logic [WIDTH-1:0]     CHUNK_MASK = ~({WIDTH{1'b1}} << CHUNK);
    localparam logic [LOG_NCHUNK-1:0] POS_TOP   = LOG_NCHUNK'(NCHUNK - 1);
    localparam logic [LOG_NCHUNK-1:0] POS_ONE   = LOG_NCHUNK'(1);
    localparam logic [LOG_DEPTH:0]   CNT_ONE    = (LOG_DEPTH + 1)'(1);
    localparam logic [LOG_DEPTH:0]   CNT_FULL   = (LOG_DEPTH + 1)'(DEPTH);
    localparam logic [LOG_DEPTH-1:0] PTR_ONE    = LOG_DEPTH'(1);

    typedef enum logic [1:0] {IDLE, IDX, VAL} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sreg_q, sreg_d;
    logic [LOG_NCHUNK-1:0] pos_q, pos_d;
    logic                  m_q, m_d;
    logic [WIDTH-1:0]      mem [DEPTH];
    logic [LOG_DEPTH-1:0]  wr_ptr_q, rd_ptr_q;
    logic [LOG_DEPTH:0]    count_q, count_d;
    logic                  error_q, error_d;
    logic                  out_nd_q, out_nd_d;
    logic [WIDTH-1:0]      out_data_q, out_data_d;
    logic                  pop, push, fifo_empty, fifo_full;
    logic [WIDTH-1:0]      shifted;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);

    // Slice FSM; the pop at pos==0 chains the next word with no idle cycle.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        pos_d   = pos_q;
        m_d     = m_q;
        pop     = 1'b0;
        if (!error_q) begin
            case (state_q)
                IDLE: if (!fifo_empty) pop = 1'b1;
                IDX:  state_d = VAL;
                VAL: begin
                    if (pos_q != '0) begin
                        pos_d   = pos_q - POS_ONE;
                        state_d = m_q ? VAL : IDX;
                    end else if (!fifo_empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (pop) begin
                sreg_d  = mem[rd_ptr_q];
                pos_d   = POS_TOP;
                m_d     = bus.mode_i;
                state_d = bus.mode_i ? VAL : IDX;
            end
        end
    end

    // A push into a full FIFO is still legal when a pop frees a slot this cycle.
    always_comb begin
        push    = 1'b0;
        error_d = error_q;
        if (bus.in_nd_i && !error_q) begin
            if (!fifo_full || pop) push = 1'b1;
            else                   error_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)      count_d = count_q + CNT_ONE;
        else if (pop && !push) count_d = count_q - CNT_ONE;
    end

    // Outputs are computed from next state so they leave the block registered.
    always_comb begin
        shifted  = sreg_d >> (int'(pos_d) * CHUNK);
        out_nd_d = error_d || (state_d != IDLE);
        if (error_d)              out_data_d = ERRORCODE;
        else if (state_d == IDX)  out_data_d = WIDTH'(pos_d);
        else if (state_d == VAL)  out_data_d = shifted & CHUNK_MASK;
        else                      out_data_d = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            pos_q      <= '0;
            m_q        <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            error_q    <= 1'b0;
            out_nd_q   <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            pos_q      <= pos_d;
            m_q        <= m_d;
            count_q    <= count_d;
            error_q    <= error_d;
            out_nd_q   <= out_nd_d;
            out_data_q <= out_data_d;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.in_data_i;
    end

    assign bus.out_data_o   = out_data_q;
    assign bus.out_nd_o     = out_nd_q;
    assign bus.error_o      = error_q;
    assign bus.fifo_count_o = count_q;
endmodule

// File: tb/tb_bits_buffered.sv
// Bench for bits_buffered: an 8-bit/CHUNK=1 instance and a 32-bit/CHUNK=8 instance,
// directed vectors, corner sequences and a queue-based reference for random traffic.
module tb_bits_buffered;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bits_buffered_if #(.WIDTH(8),  .LOG_DEPTH(2)) b8 ();
    bits_buffered_if #(.WIDTH(32), .LOG_DEPTH(2)) b32 ();

    bits_buffered #(.WIDTH(8), .CHUNK(1), .LOG_NCHUNK(3), .DEPTH(4), .LOG_DEPTH(2),
                    .ERRORCODE(8'hFF)) u8 (.clk(clk), .rst(rst), .bus(b8));
    bits_buffered #(.WIDTH(32), .CHUNK(8), .LOG_NCHUNK(2), .DEPTH(4), .LOG_DEPTH(2),
                    .ERRORCODE(32'hFFFFFFFF)) u32 (.clk(clk), .rst(rst), .bus(b32));

    int checks = 0;
    int errors = 0;

    // Reference for the 32-bit instance: pending words and pending output words.
    logic [31:0] mq_fifo[$];
    logic [31:0] mq_stream[$];
    bit          m_err;
    logic [31:0] got32[$];
    logic [31:0] exp32[$];

    typedef struct {
        bit          sel;
        logic        nd;
        logic [31:0] data;
        logic        mode;
        logic        exp_nd;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vt[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mq_fifo.delete();
        mq_stream.delete();
        m_err = 1'b0;
    endtask

    task automatic model_edge();
        bit do_pop;
        logic [31:0] w;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_err) return;
        do_pop = (mq_stream.size() <= 1) && (mq_fifo.size() != 0);
        if (mq_stream.size() != 0) void'(mq_stream.pop_front());
        if (do_pop) begin
            w = mq_fifo.pop_front();
            for (int p = 3; p >= 0; p--) begin
                if (!b32.mode_i) mq_stream.push_back(32'(p));
                mq_stream.push_back((w >> (8 * p)) & 32'hFF);
            end
        end
        if (b32.in_nd_i) begin
            if (mq_fifo.size() < 4) mq_fifo.push_back(b32.in_data_i);
            else                    m_err = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        b8.in_nd_i  = 1'b0; b8.in_data_i  = '0; b8.mode_i  = 1'b0;
        b32.in_nd_i = 1'b0; b32.in_data_i = '0; b32.mode_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic collect32(input int ncyc, input int npush, input logic [31:0] words[4],
                             input int mode_from, output int first, output int last,
                             output int maxc);
        got32.delete();
        first = -1; last = -1; maxc = 0;
        for (int c = 0; c < ncyc; c++) begin
            b32.in_nd_i   = (c < npush);
            b32.in_data_i = (c < npush) ? words[c & 3] : 32'h0;
            b32.mode_i    = (c >= mode_from);
            tick();
            if (int'(b32.fifo_count_o) > maxc) maxc = int'(b32.fifo_count_o);
            if (b32.out_nd_o) begin
                got32.push_back(b32.out_data_o);
                if (first < 0) first = c;
                last = c;
            end
        end
        b32.in_nd_i = 1'b0;
    endtask

    task automatic compare_stream(input string tag, input int first, input int last);
        check({tag, "_count"}, got32.size(), exp32.size());
        check({tag, "_latency"}, first, 1);
        check({tag, "_contig"}, last - first + 1, exp32.size());
        for (int k = 0; k < exp32.size() && k < got32.size(); k++)
            check($sformatf("%s_out%0d", tag, k), got32[k], exp32[k]);
    endtask

    task automatic run_random(input string tag, input int ncyc, input int rate);
        for (int n = 0; n < ncyc; n++) begin
            b32.in_nd_i   = ($urandom_range(0, rate - 1) == 0);
            b32.in_data_i = $urandom;
            b32.mode_i    = 1'($urandom_range(0, 1));
            tick();
            check($sformatf("%s%0d_nd", tag, n), b32.out_nd_o, m_err || (mq_stream.size() != 0));
            if (m_err)
                check($sformatf("%s%0d_data", tag, n), b32.out_data_o, 32'hFFFFFFFF);
            else if (mq_stream.size() != 0)
                check($sformatf("%s%0d_data", tag, n), b32.out_data_o, mq_stream[0]);
            check($sformatf("%s%0d_err", tag, n), b32.error_o, m_err);
            if (!m_err)
                check($sformatf("%s%0d_cnt", tag, n), b32.fifo_count_o, mq_fifo.size());
        end
        b32.in_nd_i = 1'b0;
    endtask

    initial begin
        int t1[16] = '{7, 1, 6, 0, 5, 1, 4, 0, 3, 0, 2, 1, 1, 0, 0, 1};
        logic [31:0] t2[4] = '{32'h12, 32'h34, 32'h56, 32'h78};
        logic [31:0] words[4];
        logic        an;
        logic [31:0] ad;
        int          first, last, maxc;

        idle_inputs();
        do_reset();

        check("rst8_nd", b8.out_nd_o, 0);
        check("rst8_data", b8.out_data_o, 0);
        check("rst8_err", b8.error_o, 0);
        check("rst8_cnt", b8.fifo_count_o, 0);
        check("rst32_nd", b32.out_nd_o, 0);
        check("rst32_data", b32.out_data_o, 0);
        check("rst32_err", b32.error_o, 0);
        check("rst32_cnt", b32.fifo_count_o, 0);

        // Directed vectors: 8-bit pairs dump of A5, then 32-bit values dump.
        vt.push_back('{1'b0, 1'b1, 32'hA5, 1'b0, 1'b0, 32'h0});
        for (int k = 0; k < 16; k++) vt.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'(t1[k])});
        vt.push_back('{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0});
        vt.push_back('{1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 32'h0});
        for (int k = 0; k < 4; k++) vt.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, t2[k]});
        vt.push_back('{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0});

        foreach (vt[k]) begin
            b8.in_nd_i    = !vt[k].sel && vt[k].nd;
            b8.in_data_i  = vt[k].data[7:0];
            b8.mode_i     = vt[k].mode;
            b32.in_nd_i   = vt[k].sel && vt[k].nd;
            b32.in_data_i = vt[k].data;
            b32.mode_i    = vt[k].mode;
            tick();
            if (vt[k].sel) begin an = b32.out_nd_o; ad = b32.out_data_o; end
            else           begin an = b8.out_nd_o;  ad = {24'h0, b8.out_data_o}; end
            check($sformatf("vec%0d_nd", k), an, vt[k].exp_nd);
            if (vt[k].exp_nd) check($sformatf("vec%0d_data", k), ad, vt[k].exp_data);
        end
        idle_inputs();
        tick();

        // Three queued words, values only: 12 contiguous slices, count peaks at 2.
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        collect32(16, 3, words, 0, first, last, maxc);
        exp32.delete();
        for (int i = 0; i < 3; i++)
            for (int p = 3; p >= 0; p--) exp32.push_back((words[i] >> (8 * p)) & 32'hFF);
        compare_stream("queue3", first, last);
        check("queue3_peak", maxc, 2);

        // Mode flips to values-only while word 1 is still dumping as pairs.
        for (int i = 0; i < 4; i++) words[i] = $urandom;
        collect32(16, 2, words, 3, first, last, maxc);
        exp32.delete();
        for (int p = 3; p >= 0; p--) begin
            exp32.push_back(32'(p));
            exp32.push_back((words[0] >> (8 * p)) & 32'hFF);
        end
        for (int p = 3; p >= 0; p--) exp32.push_back((words[1] >> (8 * p)) & 32'hFF);
        compare_stream("modeflip", first, last);

        // Overflow on the 8-bit instance with a slow dump.
        b8.mode_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("ovf_cnt_before", b8.fifo_count_o, 4);
            b8.in_nd_i   = 1'b1;
            b8.in_data_i = 8'($urandom);
            tick();
            check($sformatf("ovf_err%0d", i), b8.error_o, (i == 5));
        end
        b8.in_nd_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("ovf_nd%0d", i), b8.out_nd_o, 1);
            check($sformatf("ovf_data%0d", i), b8.out_data_o, 8'hFF);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("ovf_rst_nd", b8.out_nd_o, 0);
        check("ovf_rst_data", b8.out_data_o, 0);
        check("ovf_rst_err", b8.error_o, 0);
        check("ovf_rst_cnt", b8.fifo_count_o, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset pulse between edges mid-dump, then a clean dump of 8'h01.
        b8.in_nd_i = 1'b1; b8.in_data_i = 8'h5A; b8.mode_i = 1'b0;
        tick();
        b8.in_nd_i = 1'b1; b8.in_data_i = 8'hC3;
        tick();
        b8.in_nd_i = 1'b0;
        repeat (4) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        check("midrst_nd", b8.out_nd_o, 0);
        check("midrst_cnt", b8.fifo_count_o, 0);
        @(negedge clk);
        rst = 1'b0;
        first = -1; last = -1; got32.delete();
        for (int c = 0; c < 14; c++) begin
            b8.in_nd_i   = (c == 0);
            b8.in_data_i = 8'h01;
            b8.mode_i    = 1'b1;
            tick();
            if (b8.out_nd_o) begin
                got32.push_back({24'h0, b8.out_data_o});
                if (first < 0) first = c;
                last = c;
            end
        end
        b8.in_nd_i = 1'b0;
        exp32.delete();
        for (int p = 7; p >= 0; p--) exp32.push_back((p == 0) ? 32'h1 : 32'h0);
        compare_stream("postrst", first, last);

        // Random traffic on the 32-bit instance against the queue reference.
        idle_inputs();
        do_reset();
        run_random("rndA", 1500, 7);
        do_reset();
        run_random("rndB", 300, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
